// File: rtl/fp_rnd.sv
// Single-precision rounding and packing stage: takes the unrounded record from the
// arithmetic units and produces the final binary32 result and {NV,DZ,OF,UF,NX} flags.
module fp_rnd (
   input  logic        clock,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        sig,
   input  logic [10:0] expo,
   input  logic [24:0] mant,
   input  logic [1:0]  rema,
   input  logic [1:0]  fmt,
   input  logic [2:0]  rm,
   input  logic [2:0]  grs,
   input  logic        snan,
   input  logic        qnan,
   input  logic        dbz,
   input  logic        inf,
   input  logic        zero,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] result,
   output logic [4:0]  flags
);

   typedef enum logic [2:0] {
      RNE = 3'd0,
      RTZ = 3'd1,
      RDN = 3'd2,
      RUP = 3'd3,
      RMM = 3'd4
   } rmode_t;

   localparam logic [31:0] QNAN_DEFAULT = 32'h7FC00000;

   logic        s1_valid;
   logic        s1_sig;
   logic [10:0] s1_expo;
   logic [24:0] s1_mant;
   logic        s1_inc;
   logic        s1_inexact;
   rmode_t      s1_mode;
   logic        s1_spec;
   logic [31:0] s1_spec_res;
   logic [4:0]  s1_spec_flg;

   logic        s2_valid;
   logic [31:0] s2_result;
   logic [4:0]  s2_flags;

   logic        s1_en;
   logic        s2_en;

   rmode_t      mode;
   logic        inexact;
   logic        inc;
   logic        spec_hit;
   logic [31:0] spec_res;
   logic [4:0]  spec_flg;

   logic [24:0] m_sum;
   logic [24:0] m_norm;
   logic [11:0] e_fin;
   logic        ovf;
   logic        max_finite;
   logic [31:0] num_res;
   logic [4:0]  num_flg;
   logic        unused_bits;

   assign s2_en    = ~s2_valid | out_ready;
   assign s1_en    = ~s1_valid | s2_en;
   assign in_ready = s1_en & reset;

   assign out_valid = s2_valid & reset;
   assign result    = out_valid ? s2_result : 32'd0;
   assign flags     = out_valid ? s2_flags : 5'd0;

   assign unused_bits = ^{rema, m_norm[24]};

   // Stage 1 decode: rounding mode (unused encodings fall back to RNE) and increment
   assign inexact = |grs;

   always_comb begin
      mode = RNE;
      case (rm)
         3'd1:    mode = RTZ;
         3'd2:    mode = RDN;
         3'd3:    mode = RUP;
         3'd4:    mode = RMM;
         default: mode = RNE;
      endcase
   end

   always_comb begin
      inc = 1'b0;
      case (mode)
         RNE:     inc = grs[2] & (grs[1] | grs[0] | mant[0]);
         RTZ:     inc = 1'b0;
         RDN:     inc = sig & inexact;
         RUP:     inc = ~sig & inexact;
         RMM:     inc = grs[2];
         default: inc = 1'b0;
      endcase
   end

   // Special cases in priority order; any hit replaces the numeric result entirely
   always_comb begin
      spec_hit = 1'b1;
      spec_res = QNAN_DEFAULT;
      spec_flg = 5'b10000;
      if (fmt != 2'd0) begin
         spec_res = QNAN_DEFAULT;
         spec_flg = 5'b10000;
      end else if (snan) begin
         spec_res = QNAN_DEFAULT;
         spec_flg = 5'b10000;
      end else if (qnan) begin
         spec_res = QNAN_DEFAULT;
         spec_flg = 5'b00000;
      end else if (dbz) begin
         spec_res = {sig, 31'h7F800000};
         spec_flg = 5'b01000;
      end else if (inf) begin
         spec_res = {sig, 31'h7F800000};
         spec_flg = 5'b00000;
      end else if (zero) begin
         spec_res = {sig, 31'h00000000};
         spec_flg = 5'b00000;
      end else begin
         spec_hit = 1'b0;
         spec_res = 32'd0;
         spec_flg = 5'd0;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         s1_valid    <= 1'b0;
         s1_sig      <= 1'b0;
         s1_expo     <= 11'd0;
         s1_mant     <= 25'd0;
         s1_inc      <= 1'b0;
         s1_inexact  <= 1'b0;
         s1_mode     <= RNE;
         s1_spec     <= 1'b0;
         s1_spec_res <= 32'd0;
         s1_spec_flg <= 5'd0;
      end else if (s1_en) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_sig      <= sig;
            s1_expo     <= expo;
            s1_mant     <= mant;
            s1_inc      <= inc;
            s1_inexact  <= inexact;
            s1_mode     <= mode;
            s1_spec     <= spec_hit;
            s1_spec_res <= spec_res;
            s1_spec_flg <= spec_flg;
         end
      end
   end

   // Stage 2: apply increment, renormalise on carry-out, detect overflow, pack
   always_comb begin
      m_sum = s1_mant + {24'd0, s1_inc};
      if (m_sum[24]) begin
         m_norm = m_sum >> 1;
         e_fin  = {1'b0, s1_expo} + 12'd1;
      end else begin
         m_norm = m_sum;
         e_fin  = {1'b0, s1_expo};
      end
      if (s1_expo == 11'd0 && m_norm[23]) begin
         e_fin = 12'd1;
      end
      ovf        = e_fin >= 12'd255;
      max_finite = (s1_mode == RTZ) | ((s1_mode == RDN) & ~s1_sig) | ((s1_mode == RUP) & s1_sig);
      if (ovf) begin
         num_res = max_finite ? {s1_sig, 31'h7F7FFFFF} : {s1_sig, 31'h7F800000};
         num_flg = 5'b00101;
      end else begin
         num_res = {s1_sig, e_fin[7:0], m_norm[22:0]};
         num_flg = {3'b000, (e_fin[7:0] == 8'd0) & s1_inexact, s1_inexact};
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         s2_valid  <= 1'b0;
         s2_result <= 32'd0;
         s2_flags  <= 5'd0;
      end else if (s2_en) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_result <= s1_spec ? s1_spec_res : num_res;
            s2_flags  <= s1_spec ? s1_spec_flg : num_flg;
         end
      end
   end

endmodule

// File: tb/tb_fp_rnd.sv
// Bench for fp_rnd: table of rounding/special vectors through a scoreboard queue,
// plus hand-written backpressure and reset-during-stall sequences.
module tb_fp_rnd;

   logic        clock;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic        sig;
   logic [10:0] expo;
   logic [24:0] mant;
   logic [1:0]  rema;
   logic [1:0]  fmt;
   logic [2:0]  rm;
   logic [2:0]  grs;
   logic        snan, qnan, dbz, inf, zero;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic [4:0]  flags;

   typedef struct {
      logic        sig;
      logic [10:0] expo;
      logic [24:0] mant;
      logic [2:0]  grs;
      logic [2:0]  rm;
      logic [1:0]  fmt;
      logic [4:0]  spc;
      logic [31:0] res;
      logic [4:0]  flg;
   } vec_t;

   typedef struct {
      int          tag;
      logic [31:0] res;
      logic [4:0]  flg;
   } exp_t;

   vec_t vecs[$];
   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   logic        stalled = 1'b0;
   logic [31:0] held_res = 32'd0;
   logic [4:0]  held_flg = 5'd0;

   fp_rnd dut (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .sig       (sig),
      .expo      (expo),
      .mant      (mant),
      .rema      (rema),
      .fmt       (fmt),
      .rm        (rm),
      .grs       (grs),
      .snan      (snan),
      .qnan      (qnan),
      .dbz       (dbz),
      .inf       (inf),
      .zero      (zero),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .flags     (flags)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic vec_t mk(logic s, logic [10:0] e, logic [24:0] m, logic [2:0] g,
                               logic [2:0] r, logic [1:0] f, logic [4:0] sp,
                               logic [31:0] res, logic [4:0] fl);
      vec_t v;
      v.sig = s; v.expo = e; v.mant = m; v.grs = g; v.rm = r;
      v.fmt = f; v.spc = sp; v.res = res; v.flg = fl;
      return v;
   endfunction

   // Exact normal values used for the backpressure sequences
   function automatic vec_t hs_vec(int k);
      logic [7:0]  e8;
      logic [22:0] f23;
      e8  = 8'(100 + k);
      f23 = 23'(k);
      return mk(1'b0, 11'(100 + k), 25'h0800000 + 25'(k), 3'b000, 3'd0, 2'd0, 5'd0,
                {1'b0, e8, f23}, 5'd0);
   endfunction

   task automatic check_output(string name, logic [31:0] got, logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, got, want);
      end
   endtask

   task automatic drive_fields(vec_t v);
      sig  = v.sig;  expo = v.expo; mant = v.mant; grs = v.grs;
      rm   = v.rm;   fmt  = v.fmt;  rema = 2'b11;
      {snan, qnan, dbz, inf, zero} = v.spc;
   endtask

   // Present one record and wait (bounded) for it to be accepted
   task automatic apply_stimulus(vec_t v, int tag, bit push);
      exp_t x;
      bit   done;
      done = 1'b0;
      drive_fields(v);
      in_valid = 1'b1;
      for (int t = 0; t < 50 && !done; t++) begin
         @(negedge clock);
         if (in_ready) begin
            if (push) begin
               x.tag = tag; x.res = v.res; x.flg = v.flg;
               exp_q.push_back(x);
            end
            @(posedge clock);
            #1;
            done = 1'b1;
         end
      end
      if (!done) begin
         checks++;
         errors++;
         $display("[TB] FAIL accept_timeout: got in_ready 0 for 50 cycles, expected acceptance (tag %0d)", tag);
      end
   endtask

   task automatic wait_drain();
      bit done;
      done = 1'b0;
      for (int t = 0; t < 100 && !done; t++) begin
         @(posedge clock);
         #1;
         if (exp_q.size() == 0) done = 1'b1;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("[TB] FAIL drain_timeout: got %0d pending results, expected 0", exp_q.size());
      end
   endtask

   // Output monitor: scoreboard pop on each transfer, hold check while stalled
   always @(negedge clock) begin
      if (out_valid && stalled) begin
         check_output("stall_result", result, held_res);
         check_output("stall_flags", {27'd0, flags}, {27'd0, held_flg});
      end
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_output: got result 0x%h, expected no output", result);
         end else begin
            exp_t x;
            x = exp_q.pop_front();
            check_output($sformatf("rec%0d_result", x.tag), result, x.res);
            check_output($sformatf("rec%0d_flags", x.tag), {27'd0, flags}, {27'd0, x.flg});
         end
      end
      stalled  <= out_valid && !out_ready;
      held_res <= result;
      held_flg <= flags;
   end

   initial begin
      int accepted;
      int seen;
      reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      drive_fields(mk(1'b0, 11'd0, 25'd0, 3'd0, 3'd0, 2'd0, 5'd0, 32'd0, 5'd0));

      // RNE ties, carry-out, RDN/RUP, rm 7 as RNE
      vecs.push_back(mk(0, 127, 25'h0800001, 3'b100, 0, 0, 5'b00000, 32'h3F800002, 5'h01));
      vecs.push_back(mk(0, 127, 25'h0800000, 3'b100, 0, 0, 5'b00000, 32'h3F800000, 5'h01));
      vecs.push_back(mk(0, 127, 25'h0FFFFFF, 3'b110, 4, 0, 5'b00000, 32'h40000000, 5'h01));
      vecs.push_back(mk(0, 127, 25'h0FFFFFF, 3'b110, 1, 0, 5'b00000, 32'h3FFFFFFF, 5'h01));
      vecs.push_back(mk(1, 127, 25'h0800000, 3'b001, 2, 0, 5'b00000, 32'hBF800001, 5'h01));
      vecs.push_back(mk(1, 127, 25'h0800000, 3'b001, 3, 0, 5'b00000, 32'hBF800000, 5'h01));
      vecs.push_back(mk(0, 127, 25'h0800001, 3'b100, 7, 0, 5'b00000, 32'h3F800002, 5'h01));
      // Overflow
      vecs.push_back(mk(0, 254, 25'h0FFFFFF, 3'b100, 0, 0, 5'b00000, 32'h7F800000, 5'h05));
      vecs.push_back(mk(1, 300, 25'h0000000, 3'b000, 1, 0, 5'b00000, 32'hFF7FFFFF, 5'h05));
      vecs.push_back(mk(1, 300, 25'h0000000, 3'b000, 2, 0, 5'b00000, 32'hFF800000, 5'h05));
      vecs.push_back(mk(0, 300, 25'h0000000, 3'b000, 2, 0, 5'b00000, 32'h7F7FFFFF, 5'h05));
      vecs.push_back(mk(0, 300, 25'h0000000, 3'b000, 3, 0, 5'b00000, 32'h7F800000, 5'h05));
      // Subnormal
      vecs.push_back(mk(0, 0, 25'h0000001, 3'b010, 3, 0, 5'b00000, 32'h00000002, 5'h03));
      vecs.push_back(mk(0, 0, 25'h07FFFFF, 3'b100, 0, 0, 5'b00000, 32'h00800000, 5'h01));
      vecs.push_back(mk(0, 0, 25'h0000004, 3'b000, 0, 0, 5'b00000, 32'h00000004, 5'h00));
      // Specials {snan,qnan,dbz,inf,zero}
      vecs.push_back(mk(0, 127, 25'h0800000, 3'b000, 0, 0, 5'b10010, 32'h7FC00000, 5'h10));
      vecs.push_back(mk(1, 127, 25'h0800000, 3'b000, 0, 0, 5'b00100, 32'hFF800000, 5'h08));
      vecs.push_back(mk(1, 127, 25'h0800000, 3'b000, 0, 0, 5'b00001, 32'h80000000, 5'h00));
      vecs.push_back(mk(0, 127, 25'h0800000, 3'b000, 0, 1, 5'b00000, 32'h7FC00000, 5'h10));
      vecs.push_back(mk(0, 127, 25'h0800000, 3'b111, 0, 0, 5'b01000, 32'h7FC00000, 5'h00));
      vecs.push_back(mk(0, 127, 25'h0800000, 3'b000, 0, 0, 5'b00010, 32'h7F800000, 5'h00));

      repeat (3) @(posedge clock);
      #1;
      check_output("reset_out_valid", {31'd0, out_valid}, 32'd0);
      check_output("reset_in_ready", {31'd0, in_ready}, 32'd0);
      check_output("reset_result", result, 32'd0);
      check_output("reset_flags", {27'd0, flags}, 32'd0);
      reset = 1'b1;
      #1;
      check_output("release_in_ready", {31'd0, in_ready}, 32'd1);

      // Latency on an isolated record, then the rest back-to-back
      apply_stimulus(vecs[0], 0, 1'b1);
      in_valid = 1'b0;
      check_output("latency_cycle1", {31'd0, out_valid}, 32'd0);
      @(posedge clock);
      #1;
      check_output("latency_cycle2", {31'd0, out_valid}, 32'd1);
      wait_drain();
      for (int i = 1; i < vecs.size(); i++) apply_stimulus(vecs[i], i, 1'b1);
      in_valid = 1'b0;
      wait_drain();

      // Backpressure: 6 cycles of out_ready=0 with records offered every cycle
      out_ready = 1'b0;
      accepted  = 0;
      for (int c = 0; c < 6; c++) begin
         drive_fields(hs_vec(accepted));
         in_valid = 1'b1;
         @(negedge clock);
         if (in_ready) begin
            exp_t x;
            x.tag = 100 + accepted; x.res = hs_vec(accepted).res; x.flg = 5'd0;
            exp_q.push_back(x);
            accepted++;
         end
         @(posedge clock);
         #1;
      end
      check_output("stall_accepts", 32'(accepted), 32'd2);
      check_output("stall_in_ready", {31'd0, in_ready}, 32'd0);
      out_ready = 1'b1;
      for (int k = accepted; k < 5; k++) apply_stimulus(hs_vec(k), 100 + k, 1'b1);
      in_valid = 1'b0;
      wait_drain();

      // Reset during a full stall discards everything in flight
      out_ready = 1'b0;
      apply_stimulus(hs_vec(7), 200, 1'b0);
      apply_stimulus(hs_vec(8), 201, 1'b0);
      in_valid = 1'b0;
      @(posedge clock);
      #1;
      check_output("full_in_ready", {31'd0, in_ready}, 32'd0);
      reset = 1'b0;
      #1;
      check_output("midreset_out_valid", {31'd0, out_valid}, 32'd0);
      check_output("midreset_in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clock);
      #1;
      check_output("midreset_out_valid_edge", {31'd0, out_valid}, 32'd0);
      check_output("midreset_in_ready_edge", {31'd0, in_ready}, 32'd0);
      check_output("midreset_result", result, 32'd0);
      reset = 1'b1;
      #1;
      check_output("rerelease_in_ready", {31'd0, in_ready}, 32'd1);
      out_ready = 1'b1;
      seen = 0;
      repeat (6) begin
         @(negedge clock);
         if (out_valid) seen++;
      end
      check_output("no_stale_output", 32'(seen), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
